uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter FREQ_MHZ, default 60: system clock frequency in MHz.
REQ-002 SHALL have parameter BAUDS, default 115200: line rate; DIV = FREQ_MHZ*1000000/BAUDS clocks per bit.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1: transmitted stop bits, 1 or 2.
REQ-006 SHALL have parameters TX_DEPTH and RX_DEPTH, default 4 each: FIFO entries, power of two, at least 2.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 resetq  input  1  reset, asynchronous and active-low.
REQ-009 tx  output  1  serial out, idle high.
REQ-010 rx  input  1  serial in, asynchronous to clk.
REQ-011 wr  input  1  push tx_data into the TX FIFO.
REQ-012 tx_data  input  8  byte to send; bits above DATA_BITS-1 are ignored.
REQ-013 tx_full  output  1  TX FIFO full.
REQ-014 busy  output  1  TX FIFO non-empty or frame in progress.
REQ-015 rd  input  1  pop the RX FIFO head.
REQ-016 rx_data  output  8  RX FIFO head, show-ahead; bits above DATA_BITS-1 read as zero.
REQ-017 valid  output  1  RX FIFO non-empty.
REQ-018 rx_parity_err, rx_frame_err, rx_overrun  output  1 each  sticky error flags.
REQ-019 clr_err  input  1  clears all three error flags.

Function
REQ-020 TX and RX SHALL each use an independent down-counting baud counter of width $clog2(DIV)+1; each bit is held exactly DIV clocks.
REQ-021 wr with tx_full=0 SHALL write the FIFO on that edge; wr with tx_full=1 SHALL be ignored and SHALL NOT corrupt FIFO contents.
REQ-022 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE with a non-empty FIFO SHALL pop and enter START on the next edge, driving tx low.
REQ-023 Frame order SHALL be: start 0, DATA_BITS LSB first, parity bit if PARITY!=0, STOP_BITS stop bits of value 1. Back-to-back frames SHALL have no idle gap.
REQ-024 Odd parity SHALL make the count of ones in data plus parity odd; even parity SHALL make it even.
REQ-025 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-026 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. A falling edge in IDLE SHALL enter START and load DIV/2; at expiry, rx=1 SHALL return to IDLE (glitch reject), otherwise sampling continues every DIV clocks at mid-bit.
REQ-027 The receiver SHALL check exactly one stop bit regardless of STOP_BITS.
REQ-028 Stop bit sampled 0: byte discarded, rx_frame_err set, FSM SHALL wait for rx=1 before returning to IDLE.
REQ-029 Parity mismatch: byte still stored, rx_parity_err set.
REQ-030 Byte completion with RX FIFO full and no rd that cycle: byte dropped, rx_overrun set. If rd is high on the same cycle, the pop and push SHALL both occur with no overrun.
REQ-031 rd with valid=0 SHALL be ignored; after a pop, rx_data SHALL show the next entry one clock later.
REQ-032 clr_err SHALL clear the flags; a new error on the same cycle SHALL take priority and the flag SHALL stay set.
REQ-033 FIFO pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full = MSBs differ and low bits equal.

Reset
REQ-034 resetq low SHALL immediately force: tx=1, both FSMs to IDLE, FIFOs empty, tx_full=0, busy=0, valid=0, all error flags 0, rx_data=0; a frame in progress is abandoned.
REQ-035 FIFO storage arrays SHALL NOT be reset.

Structure
REQ-036 A shared package uart_pkg SHALL hold the FSM state encodings, the PARITY mode constants, and the DIV and counter-width functions.
REQ-037 One sub-module uart_sync_fifo(WIDTH, DEPTH) SHALL be instantiated twice, for TX and RX.

Verification (FREQ_MHZ=10, BAUDS=1000000, DIV=10, unless noted)
REQ-038 8N1, wr 0xA5 -> tx low 1 clock after the wr edge, then bits 1,0,1,0,0,1,0,1,1, each held 10 clocks; busy clears after the stop bit.
REQ-039 Loopback tx to rx, 5 back-to-back wr of 0x01..0x05 -> tx_full high after the 5th wr; all 5 bytes are received in order with no errors.
REQ-040 RX_DEPTH=4, 5 frames received with no rd -> first 4 bytes read back intact, 5th lost, rx_overrun=1; clr_err -> 0.
REQ-041 PARITY=2, inject 0x03 with parity bit 1 -> valid=1, rx_data=0x03, rx_parity_err=1.
REQ-042 rx low for 3 clocks then high -> no byte, valid stays 0. Separately, a frame with stop bit 0 -> no byte, rx_frame_err=1.
REQ-043 Assert resetq mid-frame -> tx=1 and busy=0 immediately; the next wr sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings, parity modes and baud helpers shared by the uart_fifo slice
package uart_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic int baud_div(input int freq_mhz, input int bauds);
        return (freq_mhz * 1000000) / bauds;
    endfunction
    function automatic int cnt_width(input int div);
        return $clog2(div) + 1;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers and unreset storage
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic do_push, do_pop;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = wptr == rptr;
    assign dout    = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: UART transmitter and receiver, each buffered by a uart_sync_fifo, with sticky RX error flags
module uart_fifo
    import uart_pkg::*;
#(
    parameter int FREQ_MHZ  = 60,
    parameter int BAUDS     = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetq,
    output logic       tx,
    input  logic       rx,
    input  logic       wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       busy,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       clr_err
);
    localparam int DIV = baud_div(FREQ_MHZ, BAUDS);
    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] BIT_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic HAS_PAR = PARITY != PAR_NONE;
    localparam logic ODD = PARITY == PAR_ODD;
    logic [DATA_BITS-1:0] tx_head, tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_state, tx_bit;
    logic tx_empty, tx_pop, tx_tick, tx_par, tx_stop, tx_last_stop;
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .resetq(resetq),
        .push  (wr & ~tx_full),
        .din   (tx_data[DATA_BITS-1:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );
    assign tx_tick      = tx_cnt == '0;
    assign tx_last_stop = tx_stop == 1'(STOP_BITS - 1);
    assign tx_pop       = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick & tx_last_stop));
    assign busy         = ~tx_empty | (tx_state != S_IDLE);
    // Popping at the end of the last stop bit chains frames with no idle gap
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            tx_stop  <= 1'b0;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx       <= 1'b0;
            tx_cnt   <= BIT_LOAD;
            tx_sh    <= tx_head;
            tx_par   <= ^tx_head ^ ODD;
        end else if (tx_state != S_IDLE) begin
            tx_cnt <= tx_tick ? BIT_LOAD : tx_cnt - 1'b1;
            if (tx_tick) begin
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx       <= tx_sh[0];
                        tx_bit   <= '0;
                    end
                    S_DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            tx_state <= HAS_PAR ? S_PARITY : S_STOP;
                            tx       <= HAS_PAR ? tx_par : 1'b1;
                            tx_stop  <= 1'b0;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx_sh  <= tx_sh >> 1;
                            tx     <= tx_sh[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx       <= 1'b1;
                        tx_stop  <= 1'b0;
                    end
                    S_STOP: begin
                        tx_state <= tx_last_stop ? S_IDLE : S_STOP;
                        tx_stop  <= 1'b1;
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end
    logic rx_s1, rx_s2, rx_prev;
    logic [DATA_BITS-1:0] rx_sh, rx_head;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_state, rx_bit;
    logic rx_par, rx_wait, rx_tick, rx_stop_now, rx_done, rx_full, rx_empty, rx_pop;
    logic par_bad, frame_bad, over_bad;
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .resetq(resetq),
        .push  (rx_done),
        .din   (rx_sh),
        .pop   (rd),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );
    assign rx_tick     = rx_cnt == '0;
    assign rx_stop_now = (rx_state == S_STOP) & ~rx_wait & rx_tick;
    assign rx_done     = rx_stop_now & rx_s2;
    assign rx_pop      = rd & ~rx_empty;
    assign valid       = ~rx_empty;
    assign rx_data     = valid ? 8'(rx_head) : 8'h00;
    assign par_bad     = rx_done & HAS_PAR & (rx_par != (^rx_sh ^ ODD));
    assign frame_bad   = rx_stop_now & ~rx_s2;
    assign over_bad    = rx_done & rx_full & ~rx_pop;
    // Only the synchronized copy rx_s2 (and its delayed rx_prev) is ever looked at
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
            rx_wait  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= rx_tick ? BIT_LOAD : rx_cnt - 1'b1;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev & ~rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_bit   <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == LAST_BIT) rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (rx_tick) begin
                        rx_par   <= rx_s2;
                        rx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_wait) begin
                        if (rx_s2) begin
                            rx_wait  <= 1'b0;
                            rx_state <= S_IDLE;
                        end
                    end else if (rx_tick) begin
                        rx_state <= rx_s2 ? S_IDLE : S_STOP;
                        rx_wait  <= ~rx_s2;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_parity_err <= (rx_parity_err & ~clr_err) | par_bad;
            rx_frame_err  <= (rx_frame_err & ~clr_err) | frame_bad;
            rx_overrun    <= (rx_overrun & ~clr_err) | over_bad;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: randomized scoreboard bench for uart_fifo (8N1 and 8E1 instances, DIV=10)
`timescale 1ns/1ps
module tb_uart_fifo;
    localparam int DIV = 10;
    logic clk = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;
    logic loop = 1'b0;
    logic rx_drv0 = 1'b1, rx_drv1 = 1'b1;
    logic wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
    logic tx0, tx1, full0, full1, busy0, busy1, valid0, valid1;
    logic pe0, pe1, fe0, fe1, ov0, ov1, rx0;
    logic [7:0] rxd0, rxd1;
    logic [7:0] exp0[$], exp1[$];
    int n_checks = 0, n_fail = 0;
    assign rx0 = loop ? tx0 : rx_drv0;
    uart_fifo #(.FREQ_MHZ(10), .BAUDS(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                .TX_DEPTH(4), .RX_DEPTH(4)) u0 (
        .clk(clk), .resetq(resetq), .tx(tx0), .rx(rx0), .wr(wr0), .tx_data(txd0),
        .tx_full(full0), .busy(busy0), .rd(rd0), .rx_data(rxd0), .valid(valid0),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_overrun(ov0), .clr_err(clr0)
    );
    uart_fifo #(.FREQ_MHZ(10), .BAUDS(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                .TX_DEPTH(4), .RX_DEPTH(4)) u1 (
        .clk(clk), .resetq(resetq), .tx(tx1), .rx(rx_drv1), .wr(wr1), .tx_data(txd1),
        .tx_full(full1), .busy(busy1), .rd(rd1), .rx_data(rxd1), .valid(valid1),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_overrun(ov1), .clr_err(clr1)
    );
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask
    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Scoreboard monitor: every accepted pop must match the oldest expected byte
    always @(negedge clk) begin
        if (rd0 && valid0) begin
            if (exp0.size() == 0) fail_now("rx0 unexpected byte");
            else check("rx0 data", rxd0, exp0.pop_front());
        end
        if (rd1 && valid1) begin
            if (exp1.size() == 0) fail_now("rx1 unexpected byte");
            else check("rx1 data", rxd1, exp1.pop_front());
        end
    end
    task automatic send_frame(input int w, input logic [7:0] d, input bit add_par,
                              input bit par_val, input bit stop_val);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (add_par) bits.push_back(par_val);
        bits.push_back(stop_val);
        foreach (bits[i]) begin
            if (w == 1) rx_drv1 = bits[i];
            else rx_drv0 = bits[i];
            tick(DIV);
        end
        if (w == 1) rx_drv1 = 1'b1;
        else rx_drv0 = 1'b1;
    endtask
    function automatic bit even_par(input logic [7:0] d);
        return bit'($countones(d) % 2);
    endfunction
    task automatic wait_drain(input int w, input int limit);
        int n = 0;
        while (((w == 1) ? exp1.size() : exp0.size()) != 0 && n < limit) begin
            tick(1);
            n++;
        end
        check((w == 1) ? "rx1 bytes left after drain" : "rx0 bytes left after drain",
              (w == 1) ? exp1.size() : exp0.size(), 0);
    endtask
    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy0 && n < limit) begin
            tick(1);
            n++;
        end
        check("tx0 idle within bound", busy0, 0);
    endtask
    task automatic check_tx_frame(input logic [7:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back(1'b1);
        txd0 = d;
        wr0 = 1'b1;
        tick(1);
        wr0 = 1'b0;
        @(negedge clk);
        check("tx high before start", tx0, 1);
        foreach (bits[i]) begin
            repeat (DIV) begin
                @(negedge clk);
                check($sformatf("tx bit %0d of 0x%0h", i, d), tx0, bits[i]);
            end
        end
        check("busy during stop", busy0, 1);
        @(negedge clk);
        check("busy after stop", busy0, 0);
        check("tx idle after frame", tx0, 1);
        tick(1);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0] d;
        bit ov_exp;
        #12;
        check("reset tx", tx0, 1);
        check("reset busy", busy0, 0);
        check("reset tx_full", full0, 0);
        check("reset valid", valid0, 0);
        check("reset rx_data", rxd0, 0);
        check("reset errors", {pe0, fe0, ov0}, 0);
        tick(1);
        resetq = 1'b1;
        tick(2);
        check_tx_frame(8'hA5);
        loop = 1'b1;
        rd0 = 1'b1;
        for (int i = 1; i <= 5; i++) exp0.push_back(8'(i));
        for (int i = 1; i <= 6; i++) begin
            txd0 = 8'(i);
            wr0 = 1'b1;
            tick(1);
            if (i == 5) check("tx_full after 5th wr", full0, 1);
        end
        wr0 = 1'b0;
        wait_drain(0, 3000);
        wait_idle(1000);
        check("loopback errors", {pe0, fe0, ov0}, 0);
        tick(20);
        loop = 1'b0;
        rd0 = 1'b0;
        ov_exp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            if (exp0.size() < 4) exp0.push_back(d);
            else ov_exp = 1'b1;
            send_frame(0, d, 1'b0, 1'b0, 1'b1);
        end
        tick(5);
        check("overrun after 5 frames", ov0, int'(ov_exp));
        check("valid with full rx fifo", valid0, 1);
        rd0 = 1'b1;
        wait_drain(0, 50);
        tick(2);
        rd0 = 1'b0;
        check("valid after drain", valid0, 0);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        check("overrun after clr_err", ov0, 0);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        tick(5);
        check("parity frame valid", valid1, 1);
        check("parity frame rx_data", rxd1, 8'h03);
        check("parity error set", pe1, 1);
        exp1.push_back(8'h03);
        rd1 = 1'b1;
        wait_drain(1, 50);
        rd1 = 1'b0;
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        check("parity error cleared", pe1, 0);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            exp1.push_back(d);
            send_frame(1, d, 1'b1, even_par(d), 1'b1);
        end
        tick(5);
        rd1 = 1'b1;
        wait_drain(1, 50);
        rd1 = 1'b0;
        check("good parity frames errors", {pe1, fe1, ov1}, 0);
        rx_drv0 = 1'b0;
        tick(3);
        rx_drv0 = 1'b1;
        tick(30);
        check("glitch gives no byte", valid0, 0);
        check("glitch gives no frame error", fe0, 0);
        send_frame(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        tick(20);
        check("bad stop gives no byte", valid0, 0);
        check("frame error set", fe0, 1);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        check("frame error cleared", fe0, 0);
        d = 8'($urandom_range(0, 255));
        exp0.push_back(d);
        send_frame(0, d, 1'b0, 1'b0, 1'b1);
        tick(5);
        rd0 = 1'b1;
        wait_drain(0, 50);
        loop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, 3));
            if (!full0) begin
                d = 8'($urandom_range(0, 255));
                exp0.push_back(d);
                txd0 = d;
                wr0 = 1'b1;
                tick(1);
                wr0 = 1'b0;
            end
        end
        wait_drain(0, 5000);
        wait_idle(1000);
        check("random loopback errors", {pe0, fe0, ov0}, 0);
        tick(20);
        loop = 1'b0;
        rd0 = 1'b0;
        txd0 = 8'h5A;
        wr0 = 1'b1;
        tick(1);
        wr0 = 1'b0;
        tick(35);
        resetq = 1'b0;
        #1;
        check("tx forced high by reset", tx0, 1);
        check("busy cleared by reset", busy0, 0);
        tick(2);
        resetq = 1'b1;
        tick(2);
        check_tx_frame(8'h3C);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
